fetch_flush_ctrl: RTL and testbench
===================================

Name: fetch_flush_ctrl

Overview:
- Sequences the front end after a writeback-stage exception or ERTN: pulses a pipeline-wide flush and latches the redirect target (exception entry or ERA).
- Cancels instruction-fetch responses still in flight from before the flush, then hands the redirect PC to pre-IF.
- Sits between the writeback/CSR logic and the pre-IF/IF stages. Also caps outstanding instruction-SRAM requests for the upcoming split-transaction bus.

Parameters:
- MAX_OUTSTANDING, 2: maximum instruction requests accepted but not yet answered.
- CNT_W, 2: width of the outstanding and discard counters; must hold MAX_OUTSTANDING.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- wb_ex  in  1  exception committed in writeback this cycle (already qualified by valid)
- wb_ertn  in  1  ERTN committed in writeback this cycle (already qualified by valid)
- csr_eentry  in  32  exception entry address from CSR
- csr_era  in  32  ERA value from CSR
- inst_req_fire  in  1  instruction request accepted this cycle (req & addr_ok)
- inst_resp_fire  in  1  instruction response returned this cycle (data_ok)
- redirect_ready  in  1  pre-IF issues its fetch at redirect_pc this cycle
- flush  out  1  clear all stage valids; combinational
- fetch_block  out  1  pre-IF must not raise a request
- resp_discard  out  1  current instruction response is stale and must be dropped
- redirect_valid  out  1  redirect_pc is pending for pre-IF
- redirect_pc  out  32  redirect target
- busy  out  1  state != IDLE

Behaviour:
- States: IDLE, DRAIN, REDIRECT. Reset gives IDLE, outstanding=0, discard_cnt=0, target=0. All outputs are 0 in reset and the cycle after.
- Outstanding counter, active in every state:
  - +1 on inst_req_fire only; -1 on inst_resp_fire only; unchanged when both or neither.
  - inst_resp_fire with outstanding==0, or inst_req_fire with outstanding==MAX_OUTSTANDING, is illegal; the bench asserts on either.
- flush = wb_ex | wb_ertn, in the same cycle and in any state.
- Flush event, accepted in any state:
  - target <= csr_eentry if wb_ex, else csr_era. wb_ex wins when both are high.
  - discard_cnt <= outstanding + inst_req_fire - inst_resp_fire. A request fired in the flush cycle is stale.
  - Next state is DRAIN if that sum != 0, else REDIRECT.
  - A flush arriving in DRAIN or REDIRECT restarts the same sequence with the new target.
- DRAIN:
  - fetch_block=1; resp_discard = inst_resp_fire.
  - Each inst_resp_fire decrements discard_cnt.
  - When discard_cnt==1 and inst_resp_fire, go to REDIRECT on the next cycle.
- REDIRECT:
  - redirect_valid=1, redirect_pc=target, fetch_block follows the IDLE rule.
  - On redirect_ready, go to IDLE; redirect_valid drops the next cycle.
  - inst_req_fire in this state is the redirect fetch and is counted normally.
- IDLE: fetch_block = (outstanding==MAX_OUTSTANDING); resp_discard=0; redirect_valid=0.
- redirect_pc holds the last target when redirect_valid=0 (0 after reset).
- Latency: a flush with nothing in flight raises redirect_valid one cycle after flush. Otherwise it rises one cycle after the last stale response.
- Reset mid-sequence: state, counters and target are cleared immediately; no redirect is issued.

Decomposition:
- Shared package holds:
  - state encoding constants FFC_IDLE=0, FFC_DRAIN=1, FFC_REDIRECT=2;
  - the MAX_OUTSTANDING default;
  - the ecode-independent flush-cause encoding, reused later for TLB-refill redirects.
- One sub-module, fetch_outstanding_cnt: an up/down counter with full/empty flags and CNT_W/MAX parameters. It will be reused for the data-side channel.

Test Plan:
1. wb_ex at cycle T, outstanding=0, csr_eentry=0x1c008000 → flush=1 at T; redirect_valid=1 with redirect_pc=0x1c008000 at T+1; redirect_ready at T+1 → IDLE and redirect_valid=0 at T+2.
2. wb_ertn, outstanding=2, csr_era=0x1c000100 → DRAIN with fetch_block=1; two inst_resp_fire each show resp_discard=1; REDIRECT with pc 0x1c000100 the cycle after the second response.
3. wb_ex with outstanding=1 and inst_req_fire in the same cycle → discard_cnt=2; exactly two responses discarded, the third is not.
4. IDLE, two inst_req_fire without responses → fetch_block=1 once outstanding=2; one inst_resp_fire → fetch_block=0 the next cycle.
5. wb_ex and wb_ertn in the same cycle, eentry=0x1c008000, era=0x1c000100 → redirect_pc=0x1c008000.
6. reset asserted in DRAIN with discard_cnt=1 → next cycle busy=0, fetch_block=0, resp_discard=0, redirect_valid=0, outstanding=0.

Source files
------------

// File: rtl/fetch_flush_ctrl_pkg.sv
// Shared types and defaults for the front-end flush/redirect controller.
// Also used by the counter and the data-side channel when it arrives.
package fetch_flush_ctrl_pkg;

   localparam int unsigned FFC_MAX_OUTSTANDING = 2;
   localparam int unsigned FFC_CNT_W           = 2;

   typedef enum logic [1:0] {
      FFC_IDLE     = 2'd0,
      FFC_DRAIN    = 2'd1,
      FFC_REDIRECT = 2'd2
   } ffc_state_e;

   // Redirect cause, independent of ecode; REFILL is reserved for TLB-refill entry.
   typedef enum logic [1:0] {
      FFC_CAUSE_NONE   = 2'd0,
      FFC_CAUSE_EXC    = 2'd1,
      FFC_CAUSE_ERTN   = 2'd2,
      FFC_CAUSE_REFILL = 2'd3
   } ffc_cause_e;

   // Exception has priority over ERTN when both commit together.
   function automatic ffc_cause_e ffc_flush_cause(input logic ex, input logic ertn);
      if (ex)        return FFC_CAUSE_EXC;
      else if (ertn) return FFC_CAUSE_ERTN;
      else           return FFC_CAUSE_NONE;
   endfunction

endpackage

// File: rtl/fetch_outstanding_cnt.sv
// Up/down counter of accepted-but-unanswered requests with full/empty flags.
// Illegal overflow/underflow steps are ignored rather than wrapping.
module fetch_outstanding_cnt #(
   parameter int unsigned CNT_W = 2,
   parameter int unsigned MAX   = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_inc,
   input  logic             i_dec,
   output logic [CNT_W-1:0] o_count,
   output logic             o_full,
   output logic             o_empty
);

   logic [CNT_W-1:0] r_count;
   logic             w_up;
   logic             w_dn;

   assign o_full  = (r_count == CNT_W'(MAX));
   assign o_empty = (r_count == '0);
   assign o_count = r_count;

   assign w_up = i_inc & ~i_dec & ~o_full;
   assign w_dn = i_dec & ~i_inc & ~o_empty;

   always_ff @(posedge clk) begin
      if (reset)     r_count <= '0;
      else if (w_up) r_count <= r_count + CNT_W'(1);
      else if (w_dn) r_count <= r_count - CNT_W'(1);
   end

endmodule

// File: rtl/fetch_flush_ctrl.sv
// Front-end flush sequencer: flush on WB exception/ERTN, drain stale fetch
// responses, then hand the redirect PC to pre-IF.
module fetch_flush_ctrl
   import fetch_flush_ctrl_pkg::*;
#(
   parameter int unsigned MAX_OUTSTANDING = FFC_MAX_OUTSTANDING,
   parameter int unsigned CNT_W           = FFC_CNT_W
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        wb_ex,
   input  logic        wb_ertn,
   input  logic [31:0] csr_eentry,
   input  logic [31:0] csr_era,
   input  logic        inst_req_fire,
   input  logic        inst_resp_fire,
   input  logic        redirect_ready,
   output logic        flush,
   output logic        fetch_block,
   output logic        resp_discard,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc,
   output logic        busy
);

   ffc_state_e       r_state;
   ffc_state_e       w_state_nxt;
   logic [CNT_W-1:0] r_discard_cnt;
   logic [CNT_W-1:0] w_discard_nxt;
   logic [31:0]      r_target;
   logic [31:0]      w_target_nxt;

   logic [CNT_W-1:0] w_out_cnt;
   logic             w_out_full;
   logic             w_out_empty;
   logic             w_flush;
   ffc_cause_e       w_cause;
   logic [CNT_W-1:0] w_stale;
   logic             w_fetch_block;
   logic             w_resp_discard;
   logic             w_redirect_valid;

   fetch_outstanding_cnt #(
      .CNT_W (CNT_W),
      .MAX   (MAX_OUTSTANDING)
   ) u_out_cnt (
      .clk     (clk),
      .reset   (reset),
      .i_inc   (inst_req_fire),
      .i_dec   (inst_resp_fire),
      .o_count (w_out_cnt),
      .o_full  (w_out_full),
      .o_empty (w_out_empty)
   );

   assign w_flush = wb_ex | wb_ertn;
   assign w_cause = ffc_flush_cause(wb_ex, wb_ertn);

   // Responses still owed after this cycle; a request fired now is already stale.
   assign w_stale = w_out_cnt + CNT_W'(inst_req_fire) - CNT_W'(inst_resp_fire & ~w_out_empty);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= FFC_IDLE;
         r_discard_cnt <= '0;
         r_target      <= '0;
      end else begin
         r_state       <= w_state_nxt;
         r_discard_cnt <= w_discard_nxt;
         r_target      <= w_target_nxt;
      end
   end

   always_comb begin
      w_state_nxt      = r_state;
      w_discard_nxt    = r_discard_cnt;
      w_target_nxt     = r_target;
      w_fetch_block    = w_out_full;
      w_resp_discard   = 1'b0;
      w_redirect_valid = 1'b0;

      case (r_state)
         FFC_DRAIN: begin
            w_fetch_block  = 1'b1;
            w_resp_discard = inst_resp_fire;
            if (inst_resp_fire) begin
               w_discard_nxt = r_discard_cnt - CNT_W'(1);
               if (r_discard_cnt == CNT_W'(1)) w_state_nxt = FFC_REDIRECT;
            end
         end
         FFC_REDIRECT: begin
            w_redirect_valid = 1'b1;
            if (redirect_ready) w_state_nxt = FFC_IDLE;
         end
         default: ;
      endcase

      // A new flush restarts the sequence from any state.
      if (w_flush) begin
         case (w_cause)
            FFC_CAUSE_EXC:  w_target_nxt = csr_eentry;
            FFC_CAUSE_ERTN: w_target_nxt = csr_era;
            default:        w_target_nxt = r_target;
         endcase
         w_discard_nxt = w_stale;
         w_state_nxt   = (w_stale != '0) ? FFC_DRAIN : FFC_REDIRECT;
      end
   end

   assign flush          = ~reset & w_flush;
   assign fetch_block    = ~reset & w_fetch_block;
   assign resp_discard   = ~reset & w_resp_discard;
   assign redirect_valid = ~reset & w_redirect_valid;
   assign redirect_pc    = reset ? 32'h0 : r_target;
   assign busy           = ~reset & (r_state != FFC_IDLE);

endmodule

// File: tb/tb_fetch_flush_ctrl.sv
// Directed bench for fetch_flush_ctrl: flush latency, drain, backpressure,
// cause priority, restart and mid-sequence reset.
module tb_fetch_flush_ctrl;

   localparam int unsigned MAXO = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        wb_ex, wb_ertn;
   logic [31:0] csr_eentry, csr_era;
   logic        inst_req_fire, inst_resp_fire, redirect_ready;
   logic        flush, fetch_block, resp_discard, redirect_valid, busy;
   logic [31:0] redirect_pc;

   int checks   = 0;
   int failures = 0;
   int m_out    = 0;

   always #5 clk = ~clk;

   fetch_flush_ctrl #(.MAX_OUTSTANDING(MAXO), .CNT_W(2)) dut (
      .clk            (clk),
      .reset          (reset),
      .wb_ex          (wb_ex),
      .wb_ertn        (wb_ertn),
      .csr_eentry     (csr_eentry),
      .csr_era        (csr_era),
      .inst_req_fire  (inst_req_fire),
      .inst_resp_fire (inst_resp_fire),
      .redirect_ready (redirect_ready),
      .flush          (flush),
      .fetch_block    (fetch_block),
      .resp_discard   (resp_discard),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .busy           (busy)
   );

   // Protocol guard on the stimulus itself: no response without a request, no overflow.
   always @(posedge clk) begin
      if (reset) m_out <= 0;
      else begin
         if (inst_resp_fire && m_out == 0) begin
            failures = failures + 1;
            $display("FAIL illegal_resp outstanding got=%0d required>0", m_out);
         end
         if (inst_req_fire && !inst_resp_fire && m_out == MAXO) begin
            failures = failures + 1;
            $display("FAIL illegal_req outstanding got=%0d required<%0d", m_out, MAXO);
         end
         if (inst_req_fire && !inst_resp_fire) m_out <= m_out + 1;
         else if (inst_resp_fire && !inst_req_fire && m_out > 0) m_out <= m_out - 1;
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      tick();
      tick();
      #1;
      checks++; if ({flush, fetch_block, resp_discard, redirect_valid, busy} !== 5'b0) begin
         failures++; $display("FAIL rst_outs got=%b exp=00000", {flush, fetch_block, resp_discard, redirect_valid, busy}); end
      checks++; if (redirect_pc !== 32'h0) begin
         failures++; $display("FAIL rst_pc got=%h exp=0", redirect_pc); end
      reset = 1'b0;
      tick();
      #1;
      checks++; if ({flush, fetch_block, resp_discard, redirect_valid, busy} !== 5'b0) begin
         failures++; $display("FAIL post_rst_outs got=%b exp=00000", {flush, fetch_block, resp_discard, redirect_valid, busy}); end
      checks++; if (redirect_pc !== 32'h0) begin
         failures++; $display("FAIL post_rst_pc got=%h exp=0", redirect_pc); end
   endtask

   task automatic test_flush_idle;
      tick();
      wb_ex = 1'b1; csr_eentry = 32'h1c008000;
      #1;
      checks++; if (flush !== 1'b1) begin failures++; $display("FAIL t1_flush got=%b exp=1", flush); end
      checks++; if (redirect_valid !== 1'b0) begin failures++; $display("FAIL t1_rv_early got=%b exp=0", redirect_valid); end
      tick();
      wb_ex = 1'b0; redirect_ready = 1'b1;
      #1;
      checks++; if (flush !== 1'b0) begin failures++; $display("FAIL t1_flush_drop got=%b exp=0", flush); end
      checks++; if (redirect_valid !== 1'b1) begin failures++; $display("FAIL t1_rv got=%b exp=1", redirect_valid); end
      checks++; if (redirect_pc !== 32'h1c008000) begin failures++; $display("FAIL t1_pc got=%h exp=1c008000", redirect_pc); end
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL t1_busy got=%b exp=1", busy); end
      tick();
      redirect_ready = 1'b0;
      #1;
      checks++; if (redirect_valid !== 1'b0) begin failures++; $display("FAIL t1_rv_drop got=%b exp=0", redirect_valid); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL t1_idle got=%b exp=0", busy); end
      checks++; if (redirect_pc !== 32'h1c008000) begin failures++; $display("FAIL t1_pc_hold got=%h exp=1c008000", redirect_pc); end
   endtask

   task automatic test_drain;
      tick(); inst_req_fire = 1'b1;
      tick();
      tick(); inst_req_fire = 1'b0;
      #1;
      checks++; if (fetch_block !== 1'b1) begin failures++; $display("FAIL t2_full got=%b exp=1", fetch_block); end
      wb_ertn = 1'b1; csr_era = 32'h1c000100;
      #1;
      checks++; if (flush !== 1'b1) begin failures++; $display("FAIL t2_flush got=%b exp=1", flush); end
      tick();
      wb_ertn = 1'b0;
      #1;
      checks++; if ({busy, fetch_block, redirect_valid, resp_discard} !== 4'b1100) begin
         failures++; $display("FAIL t2_drain got=%b exp=1100", {busy, fetch_block, redirect_valid, resp_discard}); end
      inst_resp_fire = 1'b1;
      #1;
      checks++; if (resp_discard !== 1'b1) begin failures++; $display("FAIL t2_disc1 got=%b exp=1", resp_discard); end
      tick();
      #1;
      checks++; if (resp_discard !== 1'b1) begin failures++; $display("FAIL t2_disc2 got=%b exp=1", resp_discard); end
      checks++; if (redirect_valid !== 1'b0) begin failures++; $display("FAIL t2_rv_early got=%b exp=0", redirect_valid); end
      tick();
      inst_resp_fire = 1'b0;
      #1;
      checks++; if (redirect_valid !== 1'b1) begin failures++; $display("FAIL t2_rv got=%b exp=1", redirect_valid); end
      checks++; if (redirect_pc !== 32'h1c000100) begin failures++; $display("FAIL t2_pc got=%h exp=1c000100", redirect_pc); end
      checks++; if (fetch_block !== 1'b0) begin failures++; $display("FAIL t2_fb_redir got=%b exp=0", fetch_block); end
      redirect_ready = 1'b1;
      tick();
      redirect_ready = 1'b0;
      #1;
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL t2_idle got=%b exp=0", busy); end
   endtask

   task automatic test_req_in_flush;
      tick(); inst_req_fire = 1'b1;
      tick(); inst_req_fire = 1'b1; wb_ex = 1'b1; csr_eentry = 32'h1c008040;
      #1;
      checks++; if (flush !== 1'b1) begin failures++; $display("FAIL t3_flush got=%b exp=1", flush); end
      tick();
      inst_req_fire = 1'b0; wb_ex = 1'b0; inst_resp_fire = 1'b1;
      #1;
      checks++; if (resp_discard !== 1'b1) begin failures++; $display("FAIL t3_disc1 got=%b exp=1", resp_discard); end
      tick();
      #1;
      checks++; if (resp_discard !== 1'b1) begin failures++; $display("FAIL t3_disc2 got=%b exp=1", resp_discard); end
      tick();
      inst_resp_fire = 1'b0;
      #1;
      checks++; if (redirect_valid !== 1'b1) begin failures++; $display("FAIL t3_rv got=%b exp=1", redirect_valid); end
      checks++; if (redirect_pc !== 32'h1c008040) begin failures++; $display("FAIL t3_pc got=%h exp=1c008040", redirect_pc); end
      inst_req_fire = 1'b1; redirect_ready = 1'b1;
      tick();
      inst_req_fire = 1'b0; redirect_ready = 1'b0; inst_resp_fire = 1'b1;
      #1;
      checks++; if (resp_discard !== 1'b0) begin failures++; $display("FAIL t3_third_kept got=%b exp=0", resp_discard); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL t3_idle got=%b exp=0", busy); end
      tick();
      inst_resp_fire = 1'b0;
   endtask

   task automatic test_backpressure;
      tick(); inst_req_fire = 1'b1;
      #1;
      checks++; if (fetch_block !== 1'b0) begin failures++; $display("FAIL t4_fb0 got=%b exp=0", fetch_block); end
      tick();
      #1;
      checks++; if (fetch_block !== 1'b0) begin failures++; $display("FAIL t4_fb1 got=%b exp=0", fetch_block); end
      tick(); inst_req_fire = 1'b0;
      #1;
      checks++; if (fetch_block !== 1'b1) begin failures++; $display("FAIL t4_fb2 got=%b exp=1", fetch_block); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL t4_busy got=%b exp=0", busy); end
      inst_resp_fire = 1'b1;
      tick(); inst_resp_fire = 1'b0;
      #1;
      checks++; if (fetch_block !== 1'b0) begin failures++; $display("FAIL t4_release got=%b exp=0", fetch_block); end
      inst_resp_fire = 1'b1;
      tick(); inst_resp_fire = 1'b0;
   endtask

   task automatic test_both_causes;
      tick();
      wb_ex = 1'b1; wb_ertn = 1'b1; csr_eentry = 32'h1c008000; csr_era = 32'h1c000100;
      #1;
      checks++; if (flush !== 1'b1) begin failures++; $display("FAIL t5_flush got=%b exp=1", flush); end
      tick();
      wb_ex = 1'b0; wb_ertn = 1'b0;
      #1;
      checks++; if (redirect_pc !== 32'h1c008000) begin failures++; $display("FAIL t5_pc got=%h exp=1c008000", redirect_pc); end
      checks++; if (redirect_valid !== 1'b1) begin failures++; $display("FAIL t5_rv got=%b exp=1", redirect_valid); end
      redirect_ready = 1'b1;
      tick();
      redirect_ready = 1'b0;
   endtask

   task automatic test_back_to_back;
      tick(); inst_req_fire = 1'b1;
      tick(); inst_req_fire = 1'b0; wb_ex = 1'b1; csr_eentry = 32'h1c00a000;
      tick(); wb_ex = 1'b0; wb_ertn = 1'b1; csr_era = 32'h1c000200;
      #1;
      checks++; if ({flush, busy, fetch_block} !== 3'b111) begin
         failures++; $display("FAIL t7_restart got=%b exp=111", {flush, busy, fetch_block}); end
      tick(); wb_ertn = 1'b0; inst_resp_fire = 1'b1;
      #1;
      checks++; if (resp_discard !== 1'b1) begin failures++; $display("FAIL t7_disc got=%b exp=1", resp_discard); end
      tick(); inst_resp_fire = 1'b0;
      #1;
      checks++; if (redirect_valid !== 1'b1) begin failures++; $display("FAIL t7_rv got=%b exp=1", redirect_valid); end
      checks++; if (redirect_pc !== 32'h1c000200) begin failures++; $display("FAIL t7_pc got=%h exp=1c000200", redirect_pc); end
      redirect_ready = 1'b1;
      tick();
      redirect_ready = 1'b0;
   endtask

   task automatic test_reset_mid;
      tick(); inst_req_fire = 1'b1;
      tick(); inst_req_fire = 1'b0; wb_ex = 1'b1; csr_eentry = 32'h1c00b000;
      tick(); wb_ex = 1'b0;
      #1;
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL t6_in_drain got=%b exp=1", busy); end
      reset = 1'b1; inst_resp_fire = 1'b1;
      #1;
      checks++; if (resp_discard !== 1'b0) begin failures++; $display("FAIL t6_disc_in_rst got=%b exp=0", resp_discard); end
      tick();
      reset = 1'b0; inst_resp_fire = 1'b0;
      #1;
      checks++; if ({busy, fetch_block, resp_discard, redirect_valid} !== 4'b0) begin
         failures++; $display("FAIL t6_cleared got=%b exp=0000", {busy, fetch_block, resp_discard, redirect_valid}); end
      checks++; if (redirect_pc !== 32'h0) begin failures++; $display("FAIL t6_pc got=%h exp=0", redirect_pc); end
      inst_req_fire = 1'b1;
      tick();
      #1;
      checks++; if ({fetch_block, redirect_valid} !== 2'b00) begin
         failures++; $display("FAIL t6_cnt1 got=%b exp=00", {fetch_block, redirect_valid}); end
      tick(); inst_req_fire = 1'b0;
      #1;
      checks++; if (fetch_block !== 1'b1) begin failures++; $display("FAIL t6_cnt2 got=%b exp=1", fetch_block); end
      inst_resp_fire = 1'b1;
      tick();
      tick(); inst_resp_fire = 1'b0;
   endtask

   initial begin
      reset = 1'b1; wb_ex = 1'b0; wb_ertn = 1'b0;
      csr_eentry = 32'h0; csr_era = 32'h0;
      inst_req_fire = 1'b0; inst_resp_fire = 1'b0; redirect_ready = 1'b0;
      test_reset();
      test_flush_idle();
      test_drain();
      test_req_in_flush();
      test_backpressure();
      test_both_causes();
      test_back_to_back();
      test_reset_mid();
      tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
